// File: rtl/unit_addr_responder.sv
// Register-bank responder: accepts tagged read/write ops, decodes the address into
// one of four banks and reports completion with the op ID after a fixed latency.
module unit_addr_responder #(
  parameter int         BANK_DEPTH     = 16,
  parameter int         ACCESS_LATENCY = 2,
  parameter logic [7:0] UNMAPPED_DATA  = 8'hFF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable_in,
  input  logic       wr_rd_op,
  input  logic       valid_in,
  input  logic [7:0] addr_in,
  input  logic [7:0] op_id_in,
  input  logic [7:0] wr_data_in,
  output logic       ready_out,
  output logic [7:0] rd_data_out,
  output logic [7:0] done_op_id,
  output logic       done_out,
  output logic       err_out
);

  localparam int IDX_W = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
  localparam int CNT_W = (ACCESS_LATENCY > 2) ? $clog2(ACCESS_LATENCY) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               init_q, init_d;
  logic               op_wr_q, op_wr_d;
  logic [7:0]         addr_q, addr_d;
  logic [7:0]         id_q, id_d;
  logic [7:0]         wdata_q, wdata_d;
  logic [7:0]         rd_data_q, rd_data_d;
  logic [7:0]         done_id_q, done_id_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               ready_c;
  logic               mapped_c;
  logic               bank_we_c;
  logic [IDX_W-1:0]   idx_c;
  logic [31:0]        bank_rd_flat;
  logic [7:0]         rd_word_c;

  assign idx_c     = addr_q[IDX_W-1:0];
  assign mapped_c  = ({1'b0, addr_q[5:0]} < 7'(BANK_DEPTH));
  assign rd_word_c = bank_rd_flat[{addr_q[7:6], 3'b000} +: 8];

  // init_q keeps ready_out low until the first edge after reset release.
  assign init_d = 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_wr_d   = op_wr_q;
    addr_d    = addr_q;
    id_d      = id_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    done_id_d = done_id_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    bank_we_c = 1'b0;
    ready_c   = (state_q == IDLE) && enable_in && init_q;

    case (state_q)
      IDLE: begin
        if (valid_in && ready_c) begin
          op_wr_d = wr_rd_op;
          addr_d  = addr_in;
          id_d    = op_id_in;
          wdata_d = wr_data_in;
          cnt_d   = CNT_W'(ACCESS_LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          err_d     = ~mapped_c;
          done_id_d = id_q;
          bank_we_c = op_wr_q && mapped_c;
          if (!op_wr_q) begin
            rd_data_d = mapped_c ? rd_word_c : UNMAPPED_DATA;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      init_q    <= 1'b0;
      op_wr_q   <= 1'b0;
      addr_q    <= '0;
      id_q      <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      done_id_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      init_q    <= init_d;
      op_wr_q   <= op_wr_d;
      addr_q    <= addr_d;
      id_q      <= id_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
      done_id_q <= done_id_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // One storage array per bank; reads are muxed through a flat vector by bank select.
  for (genvar gi = 0; gi < 4; gi++) begin : g_bank
    logic [7:0] mem_q [BANK_DEPTH];

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        for (int e = 0; e < BANK_DEPTH; e++) begin
          mem_q[e] <= '0;
        end
      end else if (bank_we_c && (addr_q[7:6] == 2'(gi))) begin
        mem_q[idx_c] <= wdata_q;
      end
    end

    assign bank_rd_flat[gi*8 +: 8] = mem_q[idx_c];
  end

  assign ready_out   = ready_c;
  assign rd_data_out = rd_data_q;
  assign done_op_id  = done_id_q;
  assign done_out    = done_q;
  assign err_out     = err_q;

endmodule

// File: tb/tb_unit_addr_responder.sv
// Directed bench for unit_addr_responder: hand-computed vectors, one line per transaction.
module tb_unit_addr_responder;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       enable_in;
  logic       wr_rd_op;
  logic       valid_in;
  logic [7:0] addr_in;
  logic [7:0] op_id_in;
  logic [7:0] wr_data_in;
  logic       ready_out;
  logic [7:0] rd_data_out;
  logic [7:0] done_op_id;
  logic       done_out;
  logic       err_out;

  int tests_run = 0;
  int tests_failed = 0;

  unit_addr_responder dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable_in  (enable_in),
    .wr_rd_op   (wr_rd_op),
    .valid_in   (valid_in),
    .addr_in    (addr_in),
    .op_id_in   (op_id_in),
    .wr_data_in (wr_data_in),
    .ready_out  (ready_out),
    .rd_data_out(rd_data_out),
    .done_op_id (done_op_id),
    .done_out   (done_out),
    .err_out    (err_out)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_op(input string tag, input logic wr, input logic [7:0] addr,
                       input logic [7:0] data, input logic [7:0] id,
                       input logic [7:0] exp_rd, input logic exp_err);
    int waited = 0;
    while (!ready_out && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, "_ready"}, ready_out, 1);
    wr_rd_op   = wr;
    addr_in    = addr;
    wr_data_in = data;
    op_id_in   = id;
    valid_in   = 1'b1;
    tick();
    valid_in = 1'b0;
    check({tag, "_busy_ready1"}, ready_out, 0);
    check({tag, "_busy_done1"}, done_out, 0);
    tick();
    check({tag, "_busy_ready2"}, ready_out, 0);
    check({tag, "_busy_done2"}, done_out, 0);
    tick();
    check({tag, "_done"}, done_out, 1);
    check({tag, "_id"}, done_op_id, id);
    check({tag, "_rd"}, rd_data_out, exp_rd);
    check({tag, "_err"}, err_out, exp_err);
    check({tag, "_ready_back"}, ready_out, 1);
    $display("[TB] %s %s addr=%02h data=%02h id=%02h -> rd=%02h err=%0b",
             tag, wr ? "WR" : "RD", addr, data, id, rd_data_out, err_out);
    tick();
    check({tag, "_done_fall"}, done_out, 0);
    check({tag, "_err_fall"}, err_out, 0);
  endtask

  initial begin
    int acc_cyc[4];
    logic [7:0] done_ids[4];
    int nacc;
    int ndone;
    int k;
    logic acc_pending;

    reset_n    = 1'b0;
    enable_in  = 1'b1;
    wr_rd_op   = 1'b0;
    valid_in   = 1'b0;
    addr_in    = 8'h00;
    op_id_in   = 8'h00;
    wr_data_in = 8'h00;

    // Power-on reset
    tick();
    tick();
    check("rst_ready", ready_out, 0);
    check("rst_done", done_out, 0);
    check("rst_err", err_out, 0);
    check("rst_rd", rd_data_out, 8'h00);
    check("rst_id", done_op_id, 8'h00);
    reset_n = 1'b1;
    tick();
    check("rel_ready", ready_out, 1);
    $display("[TB] reset released ready=%0b", ready_out);

    // Write then read back
    do_op("wr45", 1'b1, 8'h45, 8'hA5, 8'h11, 8'h00, 1'b0);
    do_op("rd45", 1'b0, 8'h45, 8'h00, 8'h12, 8'hA5, 1'b0);

    // Bank isolation
    do_op("wr01", 1'b1, 8'h01, 8'h01, 8'h13, 8'hA5, 1'b0);
    do_op("wr41", 1'b1, 8'h41, 8'h02, 8'h14, 8'hA5, 1'b0);
    do_op("wr81", 1'b1, 8'h81, 8'h03, 8'h15, 8'hA5, 1'b0);
    do_op("wrC1", 1'b1, 8'hC1, 8'h04, 8'h16, 8'hA5, 1'b0);
    do_op("rd01", 1'b0, 8'h01, 8'h00, 8'h17, 8'h01, 1'b0);
    do_op("rd41", 1'b0, 8'h41, 8'h00, 8'h18, 8'h02, 1'b0);
    do_op("rd81", 1'b0, 8'h81, 8'h00, 8'h19, 8'h03, 1'b0);
    do_op("rdC1", 1'b0, 8'hC1, 8'h00, 8'h1A, 8'h04, 1'b0);

    // Unmapped offset, and no aliasing into low offsets
    do_op("wr3F", 1'b1, 8'h3F, 8'h77, 8'h40, 8'h04, 1'b1);
    do_op("rd3F", 1'b0, 8'h3F, 8'h00, 8'hFE, 8'hFF, 1'b1);
    do_op("rd00", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    do_op("rd0F", 1'b0, 8'h0F, 8'h00, 8'hFF, 8'h00, 1'b0);

    // Enable dropped mid-op, then backpressure with valid held
    wr_rd_op = 1'b1; addr_in = 8'h82; wr_data_in = 8'h3C; op_id_in = 8'h30; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    check("en_busy_ready", ready_out, 0);
    enable_in = 1'b0;
    tick();
    check("en_busy_done", done_out, 0);
    tick();
    check("en_done", done_out, 1);
    check("en_id", done_op_id, 8'h30);
    check("en_ready_low", ready_out, 0);
    $display("[TB] en WR addr=82 data=3C id=30 completed with enable low");
    wr_rd_op = 1'b0; addr_in = 8'h82; op_id_in = 8'h31; valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_ready", ready_out, 0);
      check("bp_done", done_out, 0);
    end
    enable_in = 1'b1;
    #1;
    check("bp_ready_rise", ready_out, 1);
    tick();
    valid_in = 1'b0;
    check("bp_accepted", ready_out, 0);
    tick();
    tick();
    check("bp_done", done_out, 1);
    check("bp_id", done_op_id, 8'h31);
    check("bp_rd", rd_data_out, 8'h3C);
    $display("[TB] bp RD addr=82 id=31 -> rd=%02h", rd_data_out);
    tick();

    // Back-to-back with valid held high
    k = 0; nacc = 0; ndone = 0;
    wr_rd_op = 1'b1; addr_in = 8'hC4; wr_data_in = 8'h50; op_id_in = 8'h20; valid_in = 1'b1;
    acc_pending = ready_out;
    for (int cyc = 0; cyc < 40 && ndone < 4; cyc++) begin
      tick();
      if (acc_pending) begin
        if (nacc < 4) acc_cyc[nacc] = cyc;
        nacc++;
        k++;
        if (k < 4) begin
          addr_in    = 8'hC4 + 8'(k);
          wr_data_in = 8'h50 + 8'(k);
          op_id_in   = 8'h20 + 8'(k);
        end else begin
          valid_in = 1'b0;
        end
        acc_pending = 1'b0;
      end
      if (done_out) begin
        if (ndone < 4) done_ids[ndone] = done_op_id;
        ndone++;
        $display("[TB] b2b done id=%02h at cycle %0d", done_op_id, cyc);
      end
      if (ready_out && valid_in) acc_pending = 1'b1;
    end
    valid_in = 1'b0;
    check("b2b_nacc", nacc, 4);
    check("b2b_ndone", ndone, 4);
    if (nacc == 4 && ndone == 4) begin
      for (int i = 0; i < 4; i++) check($sformatf("b2b_id%0d", i), done_ids[i], 8'h20 + i);
      for (int i = 0; i < 3; i++) check($sformatf("b2b_gap%0d", i), acc_cyc[i+1] - acc_cyc[i], 3);
    end
    tick();
    check("b2b_no_extra", done_out, 0);
    do_op("rdC7", 1'b0, 8'hC7, 8'h00, 8'h24, 8'h53, 1'b0);

    // Reset while an op is in flight
    wr_rd_op = 1'b1; addr_in = 8'h02; wr_data_in = 8'h5A; op_id_in = 8'h60; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    reset_n  = 1'b0;
    #1;
    check("mid_rst_ready", ready_out, 0);
    check("mid_rst_done", done_out, 0);
    check("mid_rst_rd", rd_data_out, 8'h00);
    check("mid_rst_id", done_op_id, 8'h00);
    check("mid_rst_err", err_out, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_rst_no_done", done_out, 0);
    end
    reset_n = 1'b1;
    tick();
    check("mid_rel_ready", ready_out, 1);
    check("mid_rel_done", done_out, 0);
    $display("[TB] reset applied mid-op id=60");
    do_op("rd02", 1'b0, 8'h02, 8'h00, 8'h61, 8'h00, 1'b0);
    do_op("rd45c", 1'b0, 8'h45, 8'h00, 8'h62, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
